serial2parallel_in: RTL

Byte-serial receiver and input buffer for the divider datapath: the inbound counterpart of the output FIFO and parallel-to-serial path. It collects eight 8-bit bytes plus a sign flag, strobed by `push_in`, into one 65-bit word `{sign, data[63:0]}`. Completed words go into a small first-word-fall-through FIFO, which presents them to the divider core through a valid/ready handshake.

---
 rtl/serial2parallel_in_if.sv | 26 ++
 rtl/serial2parallel_in.sv | 73 +++++++
 2 files changed

// File: rtl/serial2parallel_in_if.sv
// Byte-serial producer / word consumer bundle for the divider input buffer.
// master drives bytes and ready; slave (the buffer) returns the head word and status.
interface serial2parallel_in_if #(
  parameter int DATA_WIDTH = 65
);
  logic [7:0]            data_in;
  logic                  sign_in;
  logic                  push_in;
  logic                  ready_i;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  nempty;
  logic                  nfull;
  logic [2:0]            byte_cnt;
  logic                  overflow;

  modport master (
    output data_in, sign_in, push_in, ready_i,
    input  valid_o, data_o, nempty, nfull, byte_cnt, overflow
  );

  modport slave (
    input  data_in, sign_in, push_in, ready_i,
    output valid_o, data_o, nempty, nfull, byte_cnt, overflow
  );
endinterface

// File: rtl/serial2parallel_in.sv
// Assembles 8 serial bytes + sign into {sign, data[63:0]} and queues it in a FWFT FIFO; word
// visible one cycle after the 8th byte; a word completed into a full FIFO without a pop is dropped (sticky overflow).
module serial2parallel_in #(
  parameter int DATA_WIDTH       = 65,
  parameter int BUFFER_DEPTH     = 4,
  parameter int LOG_BUFFER_DEPTH = 3
) (
  input logic                clk,
  input logic                rst,
  serial2parallel_in_if.slave bus
);
  localparam int ADDR_W = LOG_BUFFER_DEPTH - 1;

  logic [55:0]                 hold_q, hold_d;
  logic                        sign_q;
  logic [2:0]                  cnt_q;
  logic                        overflow_q;
  logic [LOG_BUFFER_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0]       mem [BUFFER_DEPTH];

  logic                  empty, full, pop, word_done, wr_en, drop;
  logic [DATA_WIDTH-1:0] wr_word;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[LOG_BUFFER_DEPTH-1] != rd_ptr_q[LOG_BUFFER_DEPTH-1]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign pop       = !empty && bus.ready_i;
  assign word_done = bus.push_in && (cnt_q == 3'd7);
  // A pop on the same edge frees the slot the completing word needs.
  assign wr_en     = word_done && (!full || pop);
  assign drop      = word_done && full && !pop;
  assign wr_word   = {sign_q, bus.data_in, hold_q};

  always_comb begin
    hold_d = hold_q;
    for (int i = 0; i < 7; i++) begin
      if (bus.push_in && cnt_q == 3'(i)) hold_d[i*8 +: 8] = bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      sign_q     <= 1'b0;
      cnt_q      <= 3'd0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      hold_q <= hold_d;
      if (bus.push_in) begin
        cnt_q <= cnt_q + 3'd1;
        if (cnt_q == 3'd0) sign_q <= bus.sign_in;
      end
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop)  overflow_q <= 1'b1;
    end
  end

  // Storage is not reset: unread slots are masked by the empty decode.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= wr_word;
  end

  assign bus.nempty   = !empty;
  assign bus.valid_o  = !empty;
  assign bus.nfull    = !full;
  assign bus.byte_cnt = cnt_q;
  assign bus.overflow = overflow_q;
  assign bus.data_o   = empty ? '0 : mem[rd_ptr_q[ADDR_W-1:0]];
endmodule
